load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 121, number of 32-bit data-memory words.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, CPU load/store request valid.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width/sign code.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, extended load data, valid with resp_valid.
REQ-012 SHALL have port resp_err, output, 1, access fault, valid with resp_valid.
REQ-013 SHALL have port mem_addr, output, 32, word index to data memory.
REQ-014 SHALL have port mem_we, output, 1, memory write strobe, memory writes on clk rising edge.
REQ-015 SHALL have port mem_wdata, output, 32, full word written.
REQ-016 SHALL have port mem_rdata, input, 32, combinational read data for mem_addr.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge in IDLE with req_valid=1, registering all req_* fields.
REQ-019 SHALL drive mem_addr = req_addr[31:2] (registered copy) and word lane = addr[1:0], little-endian.
REQ-020 Load (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU): IDLE->READ->RESP; resp_valid 2 cycles after acceptance.
REQ-021 READ SHALL capture mem_rdata; load result SHALL be the lane extracted and sign- (LB/LH) or zero- (LBU/LHU) extended to 32 bits.
REQ-022 SW (funct3 010): IDLE->WRITE->RESP; mem_we=1 for exactly the WRITE cycle with mem_wdata=req_wdata.
REQ-023 SB/SH (000/001): IDLE->READ->WRITE->RESP; WRITE word = captured word with only the addressed byte/halfword replaced.
REQ-024 RESP SHALL last one cycle, then return to IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-025 Illegal funct3 (loads 011/110/111, stores other than 000-010) SHALL go IDLE->RESP with resp_err=1 and no mem_we.
REQ-026 Word index >= DEPTH SHALL go IDLE->RESP with resp_err=1, resp_rdata=0, no mem_we.
REQ-027 mem_we SHALL be 0 in every state except WRITE; resp_rdata SHALL be 0 for stores and faults.

Reset
REQ-028 rst_n low SHALL force IDLE immediately; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no mem_we pulse and no resp_valid afterwards.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL fault per REQ-026 timing.
REQ-031 Without LSU_MISALIGN_TRAP_EN, misaligned halfword/word accesses SHALL ignore the offending low address bits (align down) and complete normally.

Structure
REQ-032 Package riscv_mem_pkg SHALL hold funct3 constants (LB..LHU, SB..SW) and the FSM state enum.
REQ-033 Sub-module lsu_align SHALL hold combinational lane extract/extend and store merge; the FSM stays in load_store_unit.

Verification
REQ-034 Memory word 2 = 0xFFFF546F; LB addr 0x08 -> resp_rdata 0x0000006F, resp_valid 2 cycles after accept.
REQ-035 Same word: LH addr 0x0A -> 0xFFFFFFFF; LHU addr 0x0A -> 0x0000FFFF; LBU addr 0x09 -> 0x00000054.
REQ-036 Word 0 = 0x32543437; SB addr 0x01 wdata 0x000000AB -> single mem_we, word 0 = 0x3254AB37, resp_valid 3 cycles after accept.
REQ-037 LW addr 0x06 with LSU_MISALIGN_TRAP_EN -> resp_err=1, no mem_we; without macro -> returns word 1.
REQ-038 SW addr 4*DEPTH -> resp_err=1, memory unchanged; rst_n pulsed during READ of an SH -> no mem_we, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: RV32I load/store funct3 codes and LSU FSM state encoding
package riscv_mem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and byte/half merge for stores
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);
  logic [1:0]  w_off;
  logic [4:0]  w_sh;
  logic [31:0] w_lane;
  logic [31:0] w_mask;
  // halfword/word offsets are aligned down so misaligned low bits are ignored
  always_comb begin
    w_off  = (i_funct3[1:0] == 2'b00) ? i_lane :
             (i_funct3[1:0] == 2'b01) ? {i_lane[1], 1'b0} : 2'b00;
    w_sh   = {w_off, 3'b000};
    w_lane = i_word >> w_sh;
    w_mask = (i_funct3[1:0] == 2'b00) ? (32'h0000_00ff << w_sh) :
             (i_funct3[1:0] == 2'b01) ? (32'h0000_ffff << w_sh) : 32'hffff_ffff;
    o_load = (i_funct3 == F3_LB)  ? {{24{w_lane[7]}}, w_lane[7:0]} :
             (i_funct3 == F3_LH)  ? {{16{w_lane[15]}}, w_lane[15:0]} :
             (i_funct3 == F3_LBU) ? {24'h0, w_lane[7:0]} :
             (i_funct3 == F3_LHU) ? {16'h0, w_lane[15:0]} : w_lane;
    o_store = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store FSM over a word-addressed data memory; define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses
module load_store_unit
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 121
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [31:0] L_DEPTH = DEPTH[31:0];
  lsu_state_t  r_state, w_next;
  logic        r_we, r_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_word;
  logic        w_legal, w_oob, w_misalign, w_fault;
  logic [31:0] w_load, w_store;
  assign w_legal = req_we ? (!req_funct3[2] && req_funct3[1:0] != 2'b11)
                          : (!req_funct3[1] || req_funct3 == F3_LW);
  assign w_oob = {2'b00, req_addr[31:2]} >= L_DEPTH;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_fault = !w_legal || w_oob || w_misalign;
  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_lane   (r_addr[1:0]),
    .i_word   (r_word),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );
  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // request capture on acceptance and memory word capture in READ
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_word   <= 32'h0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we     <= req_we;
        r_err    <= w_fault;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == READ) r_word <= mem_rdata;
    end
  // next state: faults skip memory, SW writes directly, SB/SH read-modify-write
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !req_valid ? IDLE : w_fault ? RESP :
                        (req_we && req_funct3 == F3_SW) ? WRITE : READ;
      READ:    w_next = r_we ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // outputs decoded from state; load data only for successful loads
  always_comb begin
    req_ready  = r_state == IDLE;
    resp_valid = r_state == RESP;
    resp_err   = r_state == RESP && r_err;
    resp_rdata = (r_state == RESP && !r_err && !r_we) ? w_load : 32'h0;
    mem_we     = r_state == WRITE;
    mem_addr   = {2'b00, r_addr[31:2]};
    mem_wdata  = (r_state == WRITE) ? w_store : 32'h0;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a simple memory model
module tb_load_store_unit;
  localparam int DEPTH = 121;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:DEPTH-1];
  int          we_cnt = 0;
  int          n_cmp = 0, n_bad = 0;
  int          lat, wes;
  logic [31:0] rd;
  logic        er;
  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && mem_addr < DEPTH) mem[mem_addr] <= mem_wdata;
    if (mem_we) we_cnt <= we_cnt + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int l, output logic [31:0] r,
                         output logic e, output int w);
    int w0;
    @(negedge clk);
    w0 = we_cnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    l = 0; r = 32'hdead_beef; e = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (resp_valid) begin
        l = k; r = resp_rdata; e = resp_err;
        break;
      end
    end
    w = we_cnt - w0;
  endtask
  initial begin
    int rv;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[0] = 32'h3254_3437;
    mem[1] = 32'h0bad_f00d;
    mem[2] = 32'hffff_546f;
    mem[3] = 32'h1122_3344;
    mem[DEPTH-1] = 32'h7e57_0001;
    #2;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    #20 rst_n = 1'b1;
    run_req(1'b0, 3'b000, 32'h08, 32'h0, lat, rd, er, wes);
    check("lb_lat", lat, 2); check("lb_data", rd, 32'h0000_006f); check("lb_err", {31'h0, er}, 0);
    run_req(1'b0, 3'b001, 32'h0a, 32'h0, lat, rd, er, wes);
    check("lh_data", rd, 32'hffff_ffff);
    run_req(1'b0, 3'b101, 32'h0a, 32'h0, lat, rd, er, wes);
    check("lhu_data", rd, 32'h0000_ffff);
    run_req(1'b0, 3'b100, 32'h09, 32'h0, lat, rd, er, wes);
    check("lbu_data", rd, 32'h0000_0054);
    run_req(1'b0, 3'b000, 32'h0b, 32'h0, lat, rd, er, wes);
    check("lb_neg", rd, 32'hffff_ffff);
    run_req(1'b0, 3'b010, 32'h08, 32'h0, lat, rd, er, wes);
    check("lw_data", rd, 32'hffff_546f); check("lw_we", wes, 0);
    run_req(1'b1, 3'b000, 32'h01, 32'h0000_00ab, lat, rd, er, wes);
    check("sb_lat", lat, 3); check("sb_we", wes, 1); check("sb_mem", mem[0], 32'h3254_ab37);
    check("sb_rdata", rd, 32'h0); check("sb_err", {31'h0, er}, 0);
    run_req(1'b1, 3'b001, 32'h02, 32'h1234_beef, lat, rd, er, wes);
    check("sh_lat", lat, 3); check("sh_we", wes, 1); check("sh_mem", mem[0], 32'hbeef_ab37);
    run_req(1'b1, 3'b010, 32'h04, 32'hcafe_f00d, lat, rd, er, wes);
    check("sw_lat", lat, 2); check("sw_we", wes, 1); check("sw_mem", mem[1], 32'hcafe_f00d);
    check("sw_rdata", rd, 32'h0);
    run_req(1'b0, 3'b010, 32'h06, 32'h0, lat, rd, er, wes);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err", {31'h0, er}, 1); check("lw_mis_lat", lat, 1);
    check("lw_mis_rdata", rd, 32'h0); check("lw_mis_we", wes, 0);
`else
    check("lw_mis_err", {31'h0, er}, 0); check("lw_mis_lat", lat, 2);
    check("lw_mis_rdata", rd, 32'hcafe_f00d);
`endif
    run_req(1'b0, 3'b001, 32'h0b, 32'h0, lat, rd, er, wes);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_mis_err", {31'h0, er}, 1);
`else
    check("lh_mis_data", rd, 32'hffff_ffff);
`endif
    run_req(1'b0, 3'b011, 32'h08, 32'h0, lat, rd, er, wes);
    check("ld_ill_err", {31'h0, er}, 1); check("ld_ill_lat", lat, 1); check("ld_ill_rdata", rd, 32'h0);
    run_req(1'b1, 3'b100, 32'h08, 32'h1, lat, rd, er, wes);
    check("st_ill_err", {31'h0, er}, 1); check("st_ill_we", wes, 0); check("st_ill_mem", mem[2], 32'hffff_546f);
    run_req(1'b1, 3'b010, 32'(4 * DEPTH), 32'h5a5a_5a5a, lat, rd, er, wes);
    check("sw_oob_err", {31'h0, er}, 1); check("sw_oob_lat", lat, 1); check("sw_oob_we", wes, 0);
    run_req(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, lat, rd, er, wes);
    check("lw_oob_err", {31'h0, er}, 1); check("lw_oob_rdata", rd, 32'h0);
    run_req(1'b0, 3'b010, 32'(4 * (DEPTH - 1)), 32'h0, lat, rd, er, wes);
    check("lw_last_err", {31'h0, er}, 0); check("lw_last_data", rd, 32'h7e57_0001);
    @(negedge clk);
    wes = we_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0e; req_wdata = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_ready", {31'h0, req_ready}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", {31'h0, req_ready}, 32'h1);
    check("arst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    check("arst_no_resp", rv, 0);
    check("arst_no_we", we_cnt - wes, 0);
    check("arst_mem", mem[3], 32'h1122_3344);
    check("arst_idle", {31'h0, req_ready}, 32'h1);
    run_req(1'b0, 3'b010, 32'h0c, 32'h0, lat, rd, er, wes);
    check("post_rst_lw", rd, 32'h1122_3344); check("post_rst_lat", lat, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
